// File: rtl/rt_ibex_pcs_restore_wb.sv
// rtl/rt_ibex_pcs_restore_wb.sv - drains a captured context word into the register file on mret.
// Optional second write port enabled by RT_IBEX_PCS_WB_DUAL_PORT_EN.
module rt_ibex_pcs_restore_wb #(
  parameter int unsigned NrSavedRegs  = 9,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned RegAddrWidth = 5,
  parameter logic [NrSavedRegs-1:0][RegAddrWidth-1:0] SavedRegAddrs =
    {5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd7, 5'd6, 5'd5, 5'd1}
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  restore_en_i,
  input  logic [NrSavedRegs-1:0][DataWidth-1:0] restore_data_i,
  output logic                                  rf_we_o,
  output logic [RegAddrWidth-1:0]               rf_waddr_o,
  output logic [DataWidth-1:0]                  rf_wdata_o,
  output logic                                  rf_we_b_o,
  output logic [RegAddrWidth-1:0]               rf_waddr_b_o,
  output logic [DataWidth-1:0]                  rf_wdata_b_o,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic                                  err_o
);

  localparam int unsigned IdxW = $clog2(NrSavedRegs + 1);
`ifdef RT_IBEX_PCS_WB_DUAL_PORT_EN
  localparam int unsigned Step = 2;
`else
  localparam int unsigned Step = 1;
`endif

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e                                state_q, state_d;
  logic [IdxW-1:0]                       idx_q, idx_d;
  logic [NrSavedRegs-1:0][DataWidth-1:0] hold_q, hold_d;
  logic                                  err_q;
  logic                                  last_word;

  // Last drain cycle: the remaining words fit in this cycle's write ports.
  assign last_word = (32'(idx_q) + Step >= NrSavedRegs);

`ifdef RT_IBEX_PCS_WB_DUAL_PORT_EN
  logic            b_valid;
  logic [IdxW-1:0] idx_b;
  assign b_valid = (32'(idx_q) + 1 < NrSavedRegs);
  assign idx_b   = b_valid ? idx_q + IdxW'(1) : idx_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      err_q   <= restore_en_i && (state_q == DRAIN);
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hold_d       = hold_q;
    rf_we_o      = 1'b0;
    rf_waddr_o   = '0;
    rf_wdata_o   = '0;
    rf_we_b_o    = 1'b0;
    rf_waddr_b_o = '0;
    rf_wdata_b_o = '0;
    done_o       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (restore_en_i) begin
          state_d = DRAIN;
          idx_d   = '0;
          hold_d  = restore_data_i;
        end
      end
      DRAIN: begin
        rf_we_o    = 1'b1;
        rf_waddr_o = SavedRegAddrs[idx_q];
        rf_wdata_o = hold_q[idx_q];
`ifdef RT_IBEX_PCS_WB_DUAL_PORT_EN
        if (b_valid) begin
          rf_we_b_o    = 1'b1;
          rf_waddr_b_o = SavedRegAddrs[idx_b];
          rf_wdata_b_o = hold_q[idx_b];
        end
`endif
        // A restore pulse arriving here is dropped; only err_q records it.
        if (last_word) begin
          done_o  = 1'b1;
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IdxW'(Step);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (restore_en_i && rst_ni) || (state_q == DRAIN);
  assign err_o  = err_q;

endmodule

// File: tb/tb_rt_ibex_pcs_restore_wb.sv
// tb/tb_rt_ibex_pcs_restore_wb.sv - self-checking bench for rt_ibex_pcs_restore_wb.
module tb_rt_ibex_pcs_restore_wb;
  localparam int N  = 9;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef RT_IBEX_PCS_WB_DUAL_PORT_EN
  localparam int P = 2;
`else
  localparam int P = 1;
`endif
  localparam int L = (N + P - 1) / P;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 restore_en = 1'b0;
  logic [N-1:0][DW-1:0] restore_data = '0;
  logic                 rf_we, rf_we_b, busy, done, err;
  logic [AW-1:0]        rf_waddr, rf_waddr_b;
  logic [DW-1:0]        rf_wdata, rf_wdata_b;

  int checks = 0;
  int errors = 0;
  int addr_tbl [N] = '{1, 5, 6, 7, 10, 11, 12, 13, 14};

  always #5 clk = ~clk;

  rt_ibex_pcs_restore_wb dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .restore_en_i  (restore_en),
    .restore_data_i(restore_data),
    .rf_we_o       (rf_we),
    .rf_waddr_o    (rf_waddr),
    .rf_wdata_o    (rf_wdata),
    .rf_we_b_o     (rf_we_b),
    .rf_waddr_b_o  (rf_waddr_b),
    .rf_wdata_b_o  (rf_wdata_b),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string ctx, input bit we, input int wa, input logic [31:0] wd,
                            input bit web, input int wab, input logic [31:0] wdb,
                            input bit bsy, input bit dn, input bit er);
    chk({ctx, ".we"}, 32'(rf_we), 32'(we));
    chk({ctx, ".waddr"}, 32'(rf_waddr), wa);
    chk({ctx, ".wdata"}, rf_wdata, wd);
    chk({ctx, ".we_b"}, 32'(rf_we_b), 32'(web));
    chk({ctx, ".waddr_b"}, 32'(rf_waddr_b), wab);
    chk({ctx, ".wdata_b"}, rf_wdata_b, wdb);
    chk({ctx, ".busy"}, 32'(busy), 32'(bsy));
    chk({ctx, ".done"}, 32'(done), 32'(dn));
    chk({ctx, ".err"}, 32'(err), 32'(er));
  endtask

  task automatic check_idle(input string ctx);
    check_outs(ctx, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Capture in the current cycle, then walk up to 'stop' drain cycles.
  // reissue>0 pulses restore_en again in that drain cycle with junk data.
  task automatic run_drain(input logic [N-1:0][DW-1:0] d, input int reissue, input int stop);
    int  a;
    int  b;
    bit  bv;
    restore_en   = 1'b1;
    restore_data = d;
    #1;
    check_outs("capture", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    for (int k = 1; k <= L && k <= stop; k++) begin
      a  = (k - 1) * P;
      b  = a + 1;
      bv = (P == 2) && (b < N);
      restore_en = (k == reissue);
      for (int i = 0; i < N; i++) restore_data[i] = $urandom;
      #1;
      check_outs($sformatf("drain%0d", k), 1, addr_tbl[a], d[a], bv,
                 bv ? addr_tbl[b] : 0, bv ? d[b] : 32'h0, 1, k == L,
                 (reissue > 0) && (k == reissue + 1));
      @(posedge clk); #1;
    end
    restore_en = 1'b0;
  endtask

  logic [N-1:0][DW-1:0] d;
  int gap;

  initial begin
    #1 rst_n = 1'b0;
    #2 check_idle("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check_idle("post_reset");
    @(posedge clk); #1;
    check_idle("post_reset2");

    for (int i = 0; i < N; i++) d[i] = 32'hA000_0000 + i;
    run_drain(d, 0, 99);
    check_idle("after_drain");
    @(posedge clk); #1;

    for (int i = 0; i < N; i++) d[i] = 32'h5500_0000 + 32'(i * 3);
    run_drain(d, 3, 99);
    for (int i = 0; i < N; i++) d[i] = 32'hC0DE_0000 + 32'(i);
    run_drain(d, 0, 99);
    check_idle("after_b2b");
    @(posedge clk); #1;

    for (int i = 0; i < N; i++) d[i] = $urandom;
    run_drain(d, 0, 4);
    rst_n = 1'b0;
    #1 check_idle("reset_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    for (int j = 0; j < 4; j++) begin
      check_idle("post_reset_mid");
      @(posedge clk); #1;
    end

    for (int r = 0; r < 20; r++) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        check_idle("rand_idle");
        for (int j = 1; j < gap; j++) begin
          @(posedge clk); #1;
          check_idle("rand_idle");
        end
        @(posedge clk); #1;
      end
      for (int i = 0; i < N; i++) d[i] = $urandom;
      run_drain(d, $urandom_range(0, L - 1), 99);
    end
    check_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rt_ibex_pcs_restore_wb.md
# rt_ibex_pcs_restore_wb

Register-file write-back sequencer for the preemptive context-save path. It captures the full parallel context word popped from the hardware save stack on `mret` and drains it into the core register file, one register per cycle on a single write port. While it drains, it stalls the core. It sits directly downstream of the context-save LIFO and upstream of the register-file write mux.

## Interface
- `NrSavedRegs`, default 9: number of saved architectural registers.
- `DataWidth`, default 32: register width.
- `RegAddrWidth`, default 5: register-file address width.
- `SavedRegAddrs`, default {14,13,12,11,10,7,6,5,1}: packed `[NrSavedRegs][RegAddrWidth]` table; entry i is the destination of word i (word 0 → x1).

- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `restore_en_i`  in  1  one-cycle pulse; restore data valid.
- `restore_data_i`  in  `[NrSavedRegs][DataWidth]`  context words, valid only with `restore_en_i`.
- `rf_we_o`  out  1  register-file write enable, port A.
- `rf_waddr_o`  out  `RegAddrWidth`  write address, port A.
- `rf_wdata_o`  out  `DataWidth`  write data, port A.
- `rf_we_b_o`, `rf_waddr_b_o`, `rf_wdata_b_o`  out  1 / `RegAddrWidth` / `DataWidth`  port B (see Configuration).
- `busy_o`  out  1  core must not issue or write the register file.
- `done_o`  out  1  pulse on the final write cycle.
- `err_o`  out  1  pulse: `restore_en_i` arrived while not IDLE.

Clock and reset: one clock (`clk_i`); reset (`rst_ni`) is asynchronous and active-low.

## Operation
**FSM states:** IDLE, DRAIN.
- **IDLE → DRAIN:** on `restore_en_i`.
  - Latch `restore_data_i` into the holding register.
  - Set the index counter to 0.
- **DRAIN:**
  - Drive `rf_we_o=1`, `rf_waddr_o=SavedRegAddrs[idx]`, `rf_wdata_o=hold[idx]`.
  - Increment `idx` each cycle by the number of words written.
  - On the cycle that writes the last word, assert `done_o` and move to IDLE next edge.
- **Index counter:** width `$clog2(NrSavedRegs+1)`; it never wraps and never exceeds `NrSavedRegs`.
- **`busy_o`:** `restore_en_i | (state==DRAIN)`. It is combinational so the core stalls in the capture cycle as well.
- **`restore_en_i` while in DRAIN:**
  - The pulse is ignored: the holding register and index are untouched and the drain completes.
  - `err_o` pulses the next cycle.
- **Outputs in IDLE:** all `rf_*` outputs are 0.
- **Reset, including mid-drain:**
  - State goes to IDLE, index to 0, holding register to 0.
  - All outputs are 0 immediately (asynchronous).
  - Partial writes already performed are not undone.

## Timing
- Capture cycle T (`restore_en_i`=1): `busy_o`=1, no write.
- Single-port build: writes in T+1 … T+NrSavedRegs; `done_o` at T+NrSavedRegs; `busy_o` deasserts at T+NrSavedRegs+1.
- Dual-port build: writes in T+1 … T+⌈NrSavedRegs/2⌉; `done_o` on the last of those cycles.
- A new `restore_en_i` is accepted from the cycle after `done_o` (IDLE); back-to-back restores are legal.
- `err_o` is registered: one cycle after the offending pulse, one cycle wide.
- Reset values: `rf_we_o`=0, `rf_waddr_o`=0, `rf_wdata_o`=0, port B outputs=0, `busy_o`=0, `done_o`=0, `err_o`=0.

## Configuration
- **`RT_IBEX_PCS_WB_DUAL_PORT_EN` defined:**
  - Port B drives word `idx+1` alongside port A's word `idx`; `idx` advances by 2.
  - On an odd final word, `rf_we_b_o`=0 in the last cycle.
  - Latency is ⌈NrSavedRegs/2⌉.
- **`RT_IBEX_PCS_WB_DUAL_PORT_EN` undefined:**
  - Port B outputs are tied to 0.
  - `idx` advances by 1; latency is NrSavedRegs.
- The port list is identical in both builds.

## Test plan
- **Reset state:** hold `rst_ni`=0 → all outputs 0; release → outputs stay 0, `busy_o`=0.
- **Single-port drain:** `restore_en_i` pulse with word i = 0xA000_0000+i → writes x1=0xA0000000, x5=0xA0000001 … x14=0xA0000008 in T+1..T+9; `done_o` only at T+9; `busy_o` high T..T+9.
- **Restore while draining:** second `restore_en_i` at T+3 with different data → write sequence unchanged; `err_o`=1 at T+4 only.
- **Back-to-back restores:** new `restore_en_i` in T+10 → new drain writes T+11..T+19; no `err_o`.
- **Reset mid-drain:** assert `rst_ni`=0 at T+5 → `rf_we_o` drops immediately; after release, state is IDLE and no further writes occur.
- **Dual-port build:** with `RT_IBEX_PCS_WB_DUAL_PORT_EN` and NrSavedRegs=9 → pairs (x1,x5),(x6,x7),(x10,x11),(x12,x13) in T+1..T+4; x14 alone on port A at T+5 with `rf_we_b_o`=0; `done_o` at T+5.
